// File: rtl/fnd_scan_drv.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous
// double buffering, hex/BCD decode, leading-zero blanking and per-digit blink.
module fnd_scan_drv #(
  parameter int NUM_DIG     = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int HEX_EN      = 0,
  parameter int SEG_ACT_LOW = 0,
  parameter int ENB_ACT_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   i_digit,
  input  logic [NUM_DIG-1:0]     i_dp,
  input  logic [NUM_DIG-1:0]     i_blink,
  input  logic                   i_lzb,
  input  logic                   i_upd,
  output logic                   o_busy,
  output logic                   o_frame,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIG-1:0]     o_seg_enb
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  // Inactive levels; XOR with these converts active-high internals to pin polarity.
  localparam logic [6:0]         SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic               DP_OFF  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] ENB_OFF = (ENB_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_ph_q, blink_ph_d;
  logic [4*NUM_DIG-1:0]   pend_digit_q, pend_digit_d, act_digit_q, act_digit_d;
  logic [NUM_DIG-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIG-1:0]     pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                   busy_q, busy_d;
  logic                   frame_q, frame_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NUM_DIG-1:0]     enb_q, enb_d;

  logic                   tick, last_dig, boundary, blink_wrap;
  logic [NUM_DIG-1:0]     blank_mask, enb_raw;
  logic                   zero_run;
  logic [3:0]             cur_dig;
  logic                   cur_dp, cur_blk, cur_blank;
  logic [6:0]             seg_vis;
  logic                   dp_vis;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1110011;
      4'hA: s = (HEX_EN != 0) ? 7'b1110111 : 7'b0000000;
      4'hB: s = (HEX_EN != 0) ? 7'b0011111 : 7'b0000000;
      4'hC: s = (HEX_EN != 0) ? 7'b1001110 : 7'b0000000;
      4'hD: s = (HEX_EN != 0) ? 7'b0111101 : 7'b0000000;
      4'hE: s = (HEX_EN != 0) ? 7'b1001111 : 7'b0000000;
      default: s = (HEX_EN != 0) ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick       = (presc_q == PW'(SCAN_DIV - 1));
  assign last_dig   = (idx_q == IW'(NUM_DIG - 1));
  assign boundary   = tick & last_dig;
  assign blink_wrap = (blink_cnt_q == BW'(BLINK_DIV - 1));

  // Timebase, scan index and frame-synchronous buffer swap.
  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    blink_cnt_d  = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_ph_d   = blink_wrap ? ~blink_ph_q : blink_ph_q;
    pend_digit_d = pend_digit_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    act_digit_d  = act_digit_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    busy_d       = busy_q;
    frame_d      = boundary;
    if (tick) idx_d = last_dig ? '0 : idx_q + IW'(1);
    if (boundary && busy_q) begin
      act_digit_d = pend_digit_q;
      act_dp_d    = pend_dp_q;
      act_blink_d = pend_blink_q;
      busy_d      = 1'b0;
    end
    if (i_upd) begin
      pend_digit_d = i_digit;
      pend_dp_d    = i_dp;
      pend_blink_d = i_blink;
      busy_d       = 1'b1;
    end
  end

  // Blank mask runs down from the top digit; digit 0 always stays visible.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      zero_run      = zero_run & (act_digit_q[4*k +: 4] == 4'd0);
      blank_mask[k] = i_lzb & zero_run;
    end
  end

  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_blk   = 1'b0;
    cur_blank = 1'b0;
    enb_raw   = '0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig    = act_digit_q[4*k +: 4];
        cur_dp     = act_dp_q[k];
        cur_blk    = act_blink_q[k];
        cur_blank  = blank_mask[k];
        enb_raw[k] = 1'b1;
      end
    end
    seg_vis = cur_blank ? 7'b0000000 : decode(cur_dig);
    dp_vis  = cur_dp;
    if (blink_ph_q && cur_blk) begin
      seg_vis = 7'b0000000;
      dp_vis  = 1'b0;
    end
    seg_d = seg_vis ^ SEG_OFF;
    dp_d  = dp_vis ^ DP_OFF;
    enb_d = enb_raw ^ ENB_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pend_digit_q <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      act_digit_q  <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      busy_q       <= 1'b0;
      frame_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      enb_q        <= ENB_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_digit_q <= pend_digit_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      act_digit_q  <= act_digit_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      busy_q       <= busy_d;
      frame_q      <= frame_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      enb_q        <= enb_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_frame   = frame_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;
  assign o_seg_enb = enb_q;

endmodule
